// File: rtl/pipelined_memory.sv
// Word memory with byte-enabled writes and a fixed RD_LAT read pipeline; optional zero-fill after reset.
// Requests accepted only while ready; responses are never stalled or dropped.
module pipelined_memory #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 16,
  parameter int DEPTH        = 65536,
  parameter int RD_LAT       = 1,
  parameter bit CLEAR_ON_RST = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_valid,
  input  logic [ADDR_W-1:0]   rd_addr,
  output logic                ready,
  output logic                rd_data_valid,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_t;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] dat;
  } resp_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic [IDX_W-1:0]  clr_idx_q, clr_idx_d;
  resp_t             pipe_q [RD_LAT];
  resp_t             pipe_d [RD_LAT];
  logic [DATA_W-1:0] mem_q  [DEPTH];

  logic              wr_fire, rd_fire;
  logic              wr_in, rd_in;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [BE_W-1:0]   mem_be;
  logic [DATA_W-1:0] mem_wdat;
  logic [DATA_W-1:0] rd_word;

  assign ready   = ready_q & ~rst;
  assign wr_fire = wr_valid & ready;
  assign rd_fire = rd_valid & ready;
  assign wr_in   = {1'b0, wr_addr} < DEPTH_X;
  assign rd_in   = {1'b0, rd_addr} < DEPTH_X;
  assign wr_idx  = wr_addr[IDX_W-1:0];
  assign rd_idx  = rd_addr[IDX_W-1:0];

  // ready_q is only ever set together with the move into RUN.
  always_comb begin
    state_d   = state_q;
    ready_d   = ready_q;
    clr_idx_d = clr_idx_q;
    if (rst) begin
      clr_idx_d = '0;
      if (CLEAR_ON_RST) begin
        state_d = CLEAR;
        ready_d = 1'b0;
      end else begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end else if (state_q == CLEAR) begin
      clr_idx_d = clr_idx_q + IDX_W'(1);
      if (clr_idx_q == LAST_IDX) begin
        state_d = RUN;
        ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    state_q   <= state_d;
    ready_q   <= ready_d;
    clr_idx_q <= clr_idx_d;
  end

  // One write port shared between the clear sweep and accepted writes.
  always_comb begin
    mem_we   = 1'b0;
    mem_idx  = wr_idx;
    mem_be   = wr_be;
    mem_wdat = wr_data;
    if (!rst && state_q == CLEAR) begin
      mem_we   = 1'b1;
      mem_idx  = clr_idx_q;
      mem_be   = '1;
      mem_wdat = '0;
    end else if (wr_fire && wr_in) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (mem_be[b]) mem_q[mem_idx][8*b +: 8] <= mem_wdat[8*b +: 8];
      end
    end
  end

  // Write-first: a same-cycle write to the read address is merged into the response.
  always_comb begin
    rd_word = mem_q[rd_idx];
    for (int b = 0; b < BE_W; b++) begin
      if (wr_fire && wr_in && wr_be[b] && (wr_addr == rd_addr)) begin
        rd_word[8*b +: 8] = wr_data[8*b +: 8];
      end
    end
  end

  always_comb begin
    for (int s = 0; s < RD_LAT; s++) pipe_d[s] = '0;
    if (!rst) begin
      pipe_d[0].vld = rd_fire;
      pipe_d[0].err = rd_fire & ~rd_in;
      pipe_d[0].dat = (rd_fire && rd_in) ? rd_word : '0;
      for (int s = 1; s < RD_LAT; s++) pipe_d[s] = pipe_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
  end

  assign rd_data_valid = pipe_q[RD_LAT-1].vld & ~rst;
  assign rd_err        = pipe_q[RD_LAT-1].err & ~rst;
  assign rd_data       = rst ? '0 : pipe_q[RD_LAT-1].dat;

endmodule

// File: tb/tb_pipelined_memory.sv
// Drives three differently parameterised memories with shared stimulus and checks each
// against a per-instance reference model of memory contents and scheduled responses.
module tb_pipelined_memory;

  localparam int DEP [3] = '{1024, 16, 40};
  localparam int LAT [3] = '{1, 3, 2};
  localparam int CLR [3] = '{0, 1, 1};

  logic        clk;
  logic        rst;
  logic        wr_valid, rd_valid;
  logic [15:0] wr_addr, wr_data, rd_addr;
  logic [1:0]  wr_be;
  logic [2:0]  ready, rd_data_valid, rd_err;
  logic [15:0] rd_data [3];

  int n_chk  = 0;
  int n_fail = 0;

  pipelined_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(1024), .RD_LAT(1), .CLEAR_ON_RST(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .ready(ready[0]), .rd_data_valid(rd_data_valid[0]),
    .rd_data(rd_data[0]), .rd_err(rd_err[0]));

  pipelined_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(16), .RD_LAT(3), .CLEAR_ON_RST(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .ready(ready[1]), .rd_data_valid(rd_data_valid[1]),
    .rd_data(rd_data[1]), .rd_err(rd_err[1]));

  pipelined_memory #(.DATA_W(16), .ADDR_W(16), .DEPTH(40), .RD_LAT(2), .CLEAR_ON_RST(1'b1)) u_dut2 (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .ready(ready[2]), .rd_data_valid(rd_data_valid[2]),
    .rd_data(rd_data[2]), .rd_err(rd_err[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: word contents, known-byte masks and responses keyed by due edge.
  logic [15:0] ref_mem [3][1024];
  logic [1:0]  ref_kn  [3][1024];
  logic        sched_v [3][8];
  logic        sched_e [3][8];
  logic [15:0] sched_d [3][8];
  logic [15:0] sched_m [3][8];
  int          clear_left [3];
  bit          seen = 1'b0;
  int          edge_n = 0;
  int          m_slot;
  logic        exp_v;
  logic [15:0] exp_m;

  always @(posedge clk) begin
    edge_n++;
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        clear_left[g] = (CLR[g] != 0) ? DEP[g] : 0;
        for (int s = 0; s < 8; s++) sched_v[g][s] = 1'b0;
        for (int a = 0; a < 1024; a++) ref_kn[g][a] = 2'b00;
      end else if (!seen) begin
        clear_left[g] = clear_left[g];
      end else if (clear_left[g] > 0) begin
        ref_mem[g][DEP[g] - clear_left[g]] = 16'h0000;
        ref_kn[g][DEP[g] - clear_left[g]]  = 2'b11;
        clear_left[g]--;
      end else begin
        if (wr_valid && int'(wr_addr) < DEP[g]) begin
          for (int b = 0; b < 2; b++) begin
            if (wr_be[b]) begin
              ref_mem[g][wr_addr[9:0]][8*b +: 8] = wr_data[8*b +: 8];
              ref_kn[g][wr_addr[9:0]][b] = 1'b1;
            end
          end
        end
        if (rd_valid) begin
          m_slot = (edge_n + LAT[g] - 1) % 8;
          sched_v[g][m_slot] = 1'b1;
          if (int'(rd_addr) < DEP[g]) begin
            sched_e[g][m_slot] = 1'b0;
            sched_d[g][m_slot] = ref_mem[g][rd_addr[9:0]];
            sched_m[g][m_slot] = {{8{ref_kn[g][rd_addr[9:0]][1]}}, {8{ref_kn[g][rd_addr[9:0]][0]}}};
          end else begin
            sched_e[g][m_slot] = 1'b1;
            sched_d[g][m_slot] = 16'h0000;
            sched_m[g][m_slot] = 16'hFFFF;
          end
        end
      end
    end
    if (rst) seen = 1'b1;
    #1;
    if (seen) begin
      m_slot = edge_n % 8;
      for (int g = 0; g < 3; g++) begin
        exp_v = sched_v[g][m_slot] && !rst;
        exp_m = exp_v ? sched_m[g][m_slot] : 16'hFFFF;
        chk($sformatf("g%0d rd_data_valid @%0d", g, edge_n), 32'(rd_data_valid[g]), 32'(exp_v));
        chk($sformatf("g%0d rd_err @%0d", g, edge_n), 32'(rd_err[g]), 32'(exp_v ? sched_e[g][m_slot] : 1'b0));
        chk($sformatf("g%0d rd_data @%0d", g, edge_n), 32'(rd_data[g] & exp_m),
            32'(exp_v ? (sched_d[g][m_slot] & exp_m) : 16'h0000));
        chk($sformatf("g%0d ready @%0d", g, edge_n), 32'(ready[g]), 32'(!rst && clear_left[g] == 0));
        sched_v[g][m_slot] = 1'b0;
      end
    end
  end

  task automatic drive(input logic wv, input logic [15:0] wa, input logic [15:0] wd, input logic [1:0] wbe,
                       input logic rv, input logic [15:0] ra);
    @(negedge clk);
    wr_valid = wv; wr_addr = wa; wr_data = wd; wr_be = wbe;
    rd_valid = rv; rd_addr = ra;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b0, 16'h0);
  endtask

  task automatic wait_ready();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (&ready) break;
    end
    chk("all ready after reset", 32'(&ready), 32'd1);
  endtask

  task automatic init_words();
    for (int a = 0; a < 48; a++) drive(1'b1, 16'(a), 16'hA000 + 16'(a), 2'b11, 1'b0, 16'h0);
    for (int a = 1016; a < 1024; a++) drive(1'b1, 16'(a), 16'hA000 + 16'(a), 2'b11, 1'b0, 16'h0);
    idle(1);
  endtask

  // Called on a negedge with rst high; releases it and counts cycles until instance 1 is ready.
  task automatic release_and_time(output int n1);
    rst = 1'b0;
    n1 = 0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (ready[1]) break;
      n1++;
      @(negedge clk);
    end
  endtask

  function automatic logic [15:0] pick_addr();
    if ($urandom_range(3) == 0) return 16'(1016 + $urandom_range(15));
    return 16'($urandom_range(47));
  endfunction

  int          first_i [3];
  int          n_got   [3];
  logic [15:0] got     [3][4];
  int          n_clr;
  logic [15:0] wa;

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
    rd_valid = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_ready();
    init_words();

    drive(1'b1, 16'h0010, 16'hBEEF, 2'b11, 1'b0, 16'h0);
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0010);
    idle(1);
    chk("beef valid", 32'(rd_data_valid[0]), 32'd1);
    chk("beef data", 32'(rd_data[0]), 32'h0000BEEF);
    chk("beef err", 32'(rd_err[0]), 32'd0);

    drive(1'b1, 16'h0020, 16'h1234, 2'b11, 1'b0, 16'h0);
    drive(1'b1, 16'h0020, 16'hABCD, 2'b01, 1'b1, 16'h0020);
    idle(1);
    chk("write-first merge", 32'(rd_data[0]), 32'h000012CD);
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0020);
    idle(1);
    chk("merged word stored", 32'(rd_data[0]), 32'h000012CD);

    drive(1'b1, 16'h0400, 16'h5555, 2'b11, 1'b1, 16'h0400);
    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0000);
    chk("oor read err", 32'(rd_err[0]), 32'd1);
    chk("oor read data", 32'(rd_data[0]), 32'd0);
    idle(1);
    chk("word 0 unchanged", 32'(rd_data[0]), 32'h0000A000);
    idle(6);

    for (int g = 0; g < 3; g++) begin first_i[g] = -1; n_got[g] = 0; end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 16'h0, 16'h0, 2'b00, i < 4, 16'(i));
      for (int g = 0; g < 3; g++) begin
        if (rd_data_valid[g]) begin
          if (first_i[g] < 0) first_i[g] = i;
          if (n_got[g] < 4) got[g][n_got[g]] = rd_data[g];
          n_got[g]++;
        end
      end
    end
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("g%0d burst first response", g), 32'(first_i[g]), 32'(LAT[g]));
      chk($sformatf("g%0d burst count", g), 32'(n_got[g]), 32'd4);
      for (int k = 0; k < 4; k++)
        chk($sformatf("g%0d burst data %0d", g, k), 32'(got[g][k]), 32'hA000 + 32'(k));
    end

    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    release_and_time(n_clr);
    chk("clear length", 32'(n_clr), 32'd16);
    for (int a = 0; a < 16; a++) drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'(a));
    idle(4);

    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    release_and_time(n_clr);
    chk("clear restart length", 32'(n_clr), 32'd16);
    wait_ready();

    drive(1'b0, 16'h0, 16'h0, 2'b00, 1'b1, 16'h0005);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("flushed read stays silent", 32'(rd_data_valid[2]), 32'd0);
      @(negedge clk);
    end
    wait_ready();
    init_words();

    for (int i = 0; i < 1500; i++) begin
      wa = pick_addr();
      drive(1'($urandom_range(1)), wa, 16'($urandom), 2'($urandom_range(3)),
            1'($urandom_range(1)), ($urandom_range(3) == 0) ? wa : pick_addr());
    end
    idle(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, %0d of %0d checks failed", n_fail, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
